// File: rtl/msk_pkg.sv
// +----------------------------------------------------------------------------+
// | msk_pkg : shared types, defaults and LUT helper for the MSK transmitter     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package msk_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } msk_tx_state_t;

  localparam int MSK_OSF     = 20;
  localparam int MSK_PHASE_W = 32;

  // Quarter-wave entry idx of 2**aw, rounded to nearest; evaluated only with constant arguments.
  function automatic int msk_cos_q(input int idx, input int aw, input int amp);
    real ang;
    ang = 3.14159265358979323846 * real'(idx) / (2.0 * real'(1 << aw));
    return int'($floor(real'(amp) * $cos(ang) + 0.5));
  endfunction

endpackage

`default_nettype wire

// File: rtl/msk_mod_tx_if.sv
// +----------------------------------------------------------------------------+
// | msk_mod_tx_if : bit handshake and DAC sample bundle of the MSK transmitter  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface msk_mod_tx_if #(
  parameter int DW = 16
);
  logic                 en_i;
  logic                 data_i;
  logic                 data_val_i;
  logic                 data_rdy_o;
  logic signed [DW-1:0] dac_o;
  logic                 dac_val_o;
  logic                 underflow_o;

  modport master (
    output en_i, data_i, data_val_i,
    input  data_rdy_o, dac_o, dac_val_o, underflow_o
  );

  modport slave (
    input  en_i, data_i, data_val_i,
    output data_rdy_o, dac_o, dac_val_o, underflow_o
  );
endinterface

`default_nettype wire

// File: rtl/msk_sin_lut.sv
// +----------------------------------------------------------------------------+
// | msk_sin_lut : registered quarter-wave cosine ROM with quadrant folding      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module msk_sin_lut
  import msk_pkg::*;
#(
  parameter int LUT_AW = 10,
  parameter int DW     = 16,
  parameter int AMP    = 16383
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 phase_val,
  input  logic [LUT_AW+1:0]    phase,
  output logic signed [DW-1:0] sample,
  output logic                 sample_val
);

  localparam int N = 1 << LUT_AW;

  logic [DW-1:0] rom [N];

  for (genvar i = 0; i < N; i++) begin : g_rom
    assign rom[i] = DW'(msk_cos_q(i, LUT_AW, AMP));
  end

  logic [1:0]           quad;
  logic [LUT_AW-1:0]    idx;
  logic [LUT_AW-1:0]    addr;
  logic                 is_zero;
  logic                 negate;
  logic [DW-1:0]        mag;
  logic signed [DW-1:0] folded;

  // Odd quadrants read the mirrored index; their index 0 lands exactly on a zero crossing.
  always_comb begin
    quad    = phase[LUT_AW+1:LUT_AW];
    idx     = phase[LUT_AW-1:0];
    addr    = quad[0] ? (~idx + LUT_AW'(1)) : idx;
    is_zero = quad[0] && (idx == '0);
    negate  = quad[0] ^ quad[1];
    mag     = is_zero ? '0 : rom[addr];
    folded  = negate ? -$signed(mag) : $signed(mag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample     <= '0;
      sample_val <= 1'b0;
    end else begin
      sample_val <= phase_val;
      sample     <= phase_val ? folded : '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/msk_mod_tx.sv
// +----------------------------------------------------------------------------+
// | msk_mod_tx : continuous-phase MSK modulator, one bit per OSF IF samples     |
// | Option   : MSK_TX_DIFF_EN enables differential precoding of input bits     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module msk_mod_tx
  import msk_pkg::*;
#(
  parameter int     OSF     = MSK_OSF,
  parameter int     PHASE_W = MSK_PHASE_W,
  parameter longint CAR_INC = 64'd1 << 30,
  parameter int     DW      = 16,
  parameter int     LUT_AW  = 10,
  parameter int     AMP     = 16383
) (
  input  logic         clk,
  input  logic         rst,
  msk_mod_tx_if.slave  bus
);

  localparam int                 CNT_W    = (OSF > 2) ? $clog2(OSF) : 1;
  localparam longint             QUARTER  = longint'(1) << (PHASE_W - 2);
  localparam logic [PHASE_W-1:0] CAR_STEP = PHASE_W'(CAR_INC);
  localparam logic [PHASE_W-1:0] DEV_INC  = PHASE_W'(QUARTER / OSF);
  // Last step absorbs the floor remainder so each symbol lands on exactly +/- pi/2.
  localparam logic [PHASE_W-1:0] DEV_LAST = PHASE_W'(QUARTER - longint'(OSF - 1) * (QUARTER / OSF));

  msk_tx_state_t      state;
  logic [CNT_W-1:0]   sym_cnt;
  logic [PHASE_W-1:0] car_acc;
  logic [PHASE_W-1:0] dev_acc;
  logic               tx_bit;
  logic               underflow;

  logic               at_boundary;
  logic               data_rdy;
  logic               accept;
  logic               new_bit;
  logic               next_bit;
  logic [PHASE_W-1:0] step_mag;
  logic [LUT_AW+1:0]  lut_phase;

  assign at_boundary = (state == ST_RUN) && (sym_cnt == CNT_W'(OSF - 1));
  assign data_rdy    = bus.en_i && !rst && ((state == ST_IDLE) || at_boundary);
  assign accept      = bus.data_val_i && data_rdy;

`ifdef MSK_TX_DIFF_EN
  assign new_bit = bus.data_i ^ tx_bit;
`else
  assign new_bit = bus.data_i;
`endif

  // Fill bits are defined directly on the transmitted sequence, so they skip precoding.
  assign next_bit = accept ? new_bit : ~tx_bit;
  assign step_mag = (sym_cnt == CNT_W'(OSF - 2)) ? DEV_LAST : DEV_INC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sym_cnt   <= '0;
      car_acc   <= '0;
      dev_acc   <= '0;
      tx_bit    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_RUN;
            sym_cnt <= '0;
            tx_bit  <= new_bit;
            car_acc <= CAR_STEP;
            dev_acc <= new_bit ? DEV_INC : -DEV_INC;
          end
        end
        ST_RUN: begin
          if (at_boundary) begin
            if (!bus.en_i) begin
              state   <= ST_IDLE;
              sym_cnt <= '0;
              car_acc <= '0;
              dev_acc <= '0;
              tx_bit  <= 1'b0;
            end else begin
              sym_cnt   <= '0;
              tx_bit    <= next_bit;
              car_acc   <= car_acc + CAR_STEP;
              dev_acc   <= next_bit ? dev_acc + DEV_INC : dev_acc - DEV_INC;
              underflow <= !accept;
            end
          end else begin
            sym_cnt <= sym_cnt + CNT_W'(1);
            car_acc <= car_acc + CAR_STEP;
            dev_acc <= tx_bit ? dev_acc + step_mag : dev_acc - step_mag;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign lut_phase = (LUT_AW + 2)'((car_acc + dev_acc) >> (PHASE_W - LUT_AW - 2));

  msk_sin_lut #(
    .LUT_AW (LUT_AW),
    .DW     (DW),
    .AMP    (AMP)
  ) u_lut (
    .clk        (clk),
    .rst        (rst),
    .phase_val  (state == ST_RUN),
    .phase      (lut_phase),
    .sample     (bus.dac_o),
    .sample_val (bus.dac_val_o)
  );

  assign bus.data_rdy_o  = data_rdy;
  assign bus.underflow_o = underflow;

endmodule

`default_nettype wire

// File: tb/tb_msk_mod_tx.sv
// +----------------------------------------------------------------------------+
// | tb_msk_mod_tx : symbol-table bench for msk_mod_tx (honours MSK_TX_DIFF_EN)  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_msk_mod_tx;
  import msk_pkg::*;

  localparam int          OSF      = 20;
  localparam int          PHASE_W  = 32;
  localparam int          DW       = 16;
  localparam int          LUT_AW   = 10;
  localparam int          AMP      = 16383;
  localparam logic [31:0] CAR_INC  = 32'h4000_0000;
  localparam logic [31:0] DEV_INC  = 32'd53687091;
  localparam logic [31:0] DEV_LAST = 32'd53687095;

`ifdef MSK_TX_DIFF_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  typedef struct {
    bit en;
    bit val;
    bit data;
    bit tx;
    bit uf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  msk_mod_tx_if #(.DW(DW)) bus ();

  msk_mod_tx #(
    .OSF     (OSF),
    .PHASE_W (PHASE_W),
    .CAR_INC (64'h4000_0000),
    .DW      (DW),
    .LUT_AW  (LUT_AW),
    .AMP     (AMP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int                   n_cmp = 0;
  int                   n_err = 0;
  logic                 m_run;
  logic [31:0]          m_car;
  logic [31:0]          m_dev;
  logic                 pend_val;
  logic signed [15:0]   pend_dac;
  vec_t                 vecs [29];

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int exp_cos(input logic [31:0] th);
    real c;
    int  k;
    k = int'(th[31:20]);
    c = real'(AMP) * $cos(2.0 * 3.14159265358979323846 * real'(k) / 4096.0);
    if (c >= 0.0) return int'($floor(c + 0.5));
    else          return -int'($floor(-c + 0.5));
  endfunction

  function automatic logic [31:0] dstep(input int s, input bit b);
    logic [31:0] v;
    v = (s == OSF - 1) ? DEV_LAST : DEV_INC;
    return b ? v : -v;
  endfunction

  function automatic vec_t mk(input bit en, input bit val, input bit d,
                              input bit tx_plain, input bit tx_diff, input bit uf);
    vec_t v;
    v.en = en; v.val = val; v.data = d; v.uf = uf;
    v.tx = DIFF ? tx_diff : tx_plain;
    return v;
  endfunction

  task automatic set_pend();
    pend_val = m_run;
    pend_dac = m_run ? 16'(exp_cos(m_car + m_dev)) : 16'sd0;
  endtask

  // One clock; the outputs now visible belong to the model state of the previous cycle.
  task automatic tick();
    @(posedge clk); #1;
    chk("dac_val", longint'(bus.dac_val_o), longint'(pend_val));
    chk("dac_o", longint'(bus.dac_o), longint'(pend_dac));
  endtask

  task automatic run_entry(input vec_t v);
    bit go;
    bus.en_i       = v.en;
    bus.data_val_i = v.val;
    bus.data_i     = v.data;
    #0;
    chk("data_rdy_boundary", longint'(bus.data_rdy_o), longint'(v.en));
    if (m_run) chk("dev_acc_boundary", longint'(dut.dev_acc), longint'(m_dev));
    go = v.en && (m_run || v.val);
    tick();
    bus.data_val_i = 1'b0;
    if (go) begin
      m_run = 1'b1;
      m_car = m_car + CAR_INC;
      m_dev = m_dev + dstep(0, v.tx);
    end else begin
      m_run = 1'b0;
      m_car = '0;
      m_dev = '0;
    end
    chk("underflow_start", longint'(bus.underflow_o), longint'(v.uf));
    set_pend();
    if (go) begin
      for (int s = 1; s < OSF; s++) begin
        chk("data_rdy_mid", longint'(bus.data_rdy_o), 0);
        tick();
        m_car = m_car + CAR_INC;
        m_dev = m_dev + dstep(s, v.tx);
        chk("underflow_mid", longint'(bus.underflow_o), 0);
        set_pend();
      end
    end
  endtask

  initial begin
    int nval;

    //            en val d  plain diff uf
    vecs[0]  = mk(0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 1, 1, 1, 0);
    vecs[4]  = mk(0, 1, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 1, 1, 1, 1, 0);
    vecs[7]  = mk(1, 1, 1, 1, 0, 0);
    vecs[8]  = mk(1, 1, 1, 1, 1, 0);
    vecs[9]  = mk(1, 1, 1, 1, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, 1, 0, 0, 0, 0);
    vecs[13] = mk(1, 1, 0, 0, 0, 0);
    vecs[14] = mk(1, 1, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0);
    vecs[17] = mk(1, 1, 1, 1, 1, 0);
    vecs[18] = mk(1, 1, 0, 0, 1, 0);
    vecs[19] = mk(1, 1, 1, 1, 0, 0);
    vecs[20] = mk(1, 0, 0, 0, 1, 1);
    vecs[21] = mk(1, 0, 0, 1, 0, 1);
    vecs[22] = mk(1, 0, 0, 0, 1, 1);
    vecs[23] = mk(0, 0, 0, 0, 0, 0);
    vecs[24] = mk(0, 0, 0, 0, 0, 0);
    vecs[25] = mk(1, 1, 0, 0, 0, 0);
    vecs[26] = mk(1, 1, 1, 1, 1, 0);
    vecs[27] = mk(0, 0, 0, 0, 0, 0);
    vecs[28] = mk(0, 0, 0, 0, 0, 0);

    bus.en_i = 1'b0; bus.data_val_i = 1'b0; bus.data_i = 1'b0;
    m_run = 1'b0; m_car = '0; m_dev = '0; pend_val = 1'b0; pend_dac = '0;

    // Power-on reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dac_val", longint'(bus.dac_val_o), 0);
    chk("rst_dac", longint'(bus.dac_o), 0);
    chk("rst_underflow", longint'(bus.underflow_o), 0);
    chk("rst_state", longint'(dut.state), longint'(ST_IDLE));
    rst = 1'b0;

    // Reset in the middle of a symbol
    bus.en_i = 1'b1; bus.data_val_i = 1'b1; bus.data_i = 1'b1;
    @(posedge clk); #1;
    bus.data_val_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_dac_val_before_rst", longint'(bus.dac_val_o), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_dac_val", longint'(bus.dac_val_o), 0);
    chk("mid_rst_dac", longint'(bus.dac_o), 0);
    chk("mid_rst_underflow", longint'(bus.underflow_o), 0);
    chk("mid_rst_data_rdy", longint'(bus.data_rdy_o), 0);
    chk("mid_rst_state", longint'(dut.state), longint'(ST_IDLE));
    chk("mid_rst_car_acc", longint'(dut.car_acc), 0);
    chk("mid_rst_dev_acc", longint'(dut.dev_acc), 0);
    chk("mid_rst_sym_cnt", longint'(dut.sym_cnt), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy_en1", longint'(bus.data_rdy_o), 1);
    bus.en_i = 1'b0;
    #1;
    chk("post_rst_rdy_en0", longint'(bus.data_rdy_o), 0);

    // Symbol table: idle handling, en gating, tones, boundaries, fill bits
    for (int i = 0; i < 29; i++) run_entry(vecs[i]);

    // Single bit 1: two-cycle latency, 20 samples, exact quarter-turn deviation
    bus.en_i = 1'b1; bus.data_val_i = 1'b1; bus.data_i = 1'b1;
    @(posedge clk); #1;
    bus.data_val_i = 1'b0;
    nval = 0;
    for (int c = 1; c <= 25; c++) begin
      if (bus.dac_val_o) nval++;
      if (c == 1) chk("single_latency_val", longint'(bus.dac_val_o), 0);
      if (c == 2) begin
        chk("single_first_val", longint'(bus.dac_val_o), 1);
        chk("single_first_dac", longint'(bus.dac_o), -1280);
      end
      if (c == 20) begin
        chk("single_dev_acc", longint'(dut.dev_acc), 64'h4000_0000);
        bus.en_i = 1'b0;
      end
      if (c == 21) begin
        chk("single_val_b1", longint'(bus.dac_val_o), 1);
        chk("single_state_idle", longint'(dut.state), longint'(ST_IDLE));
      end
      if (c == 22) chk("single_val_b2", longint'(bus.dac_val_o), 0);
      @(posedge clk); #1;
    end
    chk("single_sample_count", longint'(nval), 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
